// File: rtl/conv_result_streamer.sv
// conv_result_streamer: snapshots the result map on a done rising edge and streams it row-major over valid/ready (optional ReLU via CONV_STREAM_RELU_EN)
module conv_result_streamer #(
  parameter int OUT    = 7,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OUT*OUT*DATA_W-1:0] result,
  input  logic                      done,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [IDX_W-1:0]          m_row,
  output logic [IDX_W-1:0]          m_col,
  output logic                      m_last,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun
);
  localparam int N = OUT * OUT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [0:0] IDLE = 1'b0, STREAM = 1'b1;
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(OUT - 1);
  logic [0:0] state;
  logic done_d;
  logic [DATA_W-1:0] shadow [N];
  logic [IDX_W-1:0] row, col;
  logic [KW-1:0] k;
  logic [DATA_W-1:0] word;
  logic rise, start, xfer, last, col_end;
  assign rise = done & ~done_d;
  assign start = rise && state == IDLE;
  assign m_valid = state == STREAM;
  assign busy = m_valid;
  assign xfer = m_valid & m_ready;
  assign col_end = col == MAX_IDX;
  assign last = row == MAX_IDX && col_end;
  assign m_last = m_valid & last;
  assign m_row = row;
  assign m_col = col;
  assign word = shadow[k];
`ifdef CONV_STREAM_RELU_EN
  assign m_data = (m_valid && !word[DATA_W-1]) ? word : '0;
`else
  assign m_data = m_valid ? word : '0;
`endif
  // capture the whole map at frame start; frozen while streaming
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < N; i++) shadow[i] <= '0;
    else if (start) for (int i = 0; i < N; i++) shadow[i] <= result[i*DATA_W +: DATA_W];
  // frame FSM, word counters, edge detect and status flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      done_d     <= 1'b0;
      row        <= '0;
      col        <= '0;
      k          <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done_d     <= done;
      frame_done <= xfer && last;
      if (rise && state == STREAM) overrun <= 1'b1;
      if (start) begin
        state <= STREAM;
        row   <= '0;
        col   <= '0;
        k     <= '0;
      end else if (xfer) begin
        state <= last ? IDLE : STREAM;
        k     <= last ? '0 : k + 1'b1;
        col   <= col_end ? '0 : col + 1'b1;
        row   <= last ? '0 : col_end ? row + 1'b1 : row;
      end
    end
endmodule

// File: tb/tb_conv_result_streamer.sv
// tb_conv_result_streamer: directed checks of framing, handshake, snapshot, overrun, reset and ReLU
module tb_conv_result_streamer;
  localparam int OUT = 7;
  localparam int N = OUT * OUT;
  logic clk = 1'b0;
  logic rst, done, m_ready;
  logic [N*16-1:0] result;
  logic [15:0] m_data, m_row, m_col;
  logic m_valid, m_last, busy, frame_done, overrun;
  logic [15:0] exp_w [N];
  int checks = 0;
  int failures = 0;

  conv_result_streamer #(.OUT(OUT), .DATA_W(16), .IDX_W(16)) dut (
    .clk(clk), .rst(rst), .result(result), .done(done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_row(m_row), .m_col(m_col), .m_last(m_last),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load_seq();
    for (int i = 0; i < N; i++) begin
      result[i*16 +: 16] = 16'(i + 1);
      exp_w[i] = 16'(i + 1);
    end
  endtask

  // Streams one frame, checking every presented word; optionally toggles ready and glitches done
  task automatic stream_frame(input bit toggle, input int lo, input int hi);
    int e = 0;
    int cyc = 0;
    while (e < N && cyc < 400) begin
      @(negedge clk);
      check("valid", {31'b0, m_valid}, 1);
      check("data", {16'b0, m_data}, {16'b0, exp_w[e]});
      check("row", {16'b0, m_row}, e / OUT);
      check("col", {16'b0, m_col}, e % OUT);
      check("last", {31'b0, m_last}, {31'b0, e == N - 1});
      check("fd_mid", {31'b0, frame_done}, 0);
      if (e == lo) done = 1'b0;
      if (e == hi) done = 1'b1;
      m_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      if (m_ready) e++;
      cyc++;
    end
    check("frame_count", e, N);
    @(negedge clk);
    check("fd_pulse", {31'b0, frame_done}, 1);
    check("busy_after", {31'b0, busy}, 0);
    check("valid_after", {31'b0, m_valid}, 0);
    @(negedge clk);
    check("fd_once", {31'b0, frame_done}, 0);
  endtask

  initial begin
    rst = 1'b1; done = 1'b0; m_ready = 1'b0; result = '0;
    #12;
    check("rst_valid", {31'b0, m_valid}, 0);
    check("rst_data", {16'b0, m_data}, 0);
    check("rst_rowcol", {m_row, m_col}, 0);
    check("rst_flags", {28'b0, m_last, busy, frame_done, overrun}, 0);
    load_seq();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); done = 1'b1;
    stream_frame(1'b0, -1, -1);
    done = 1'b0;
    @(negedge clk); done = 1'b1;
    @(posedge clk); #1 result = '1;
    stream_frame(1'b1, -1, -1);
    check("no_ovr", {31'b0, overrun}, 0);
    load_seq();
    done = 1'b0;
    @(negedge clk); done = 1'b1;
    stream_frame(1'b0, 15, 19);
    check("ovr_set", {31'b0, overrun}, 1);
    repeat (5) @(negedge clk);
    check("no_2nd_frame", {31'b0, busy | m_valid}, 0);
    check("ovr_sticky", {31'b0, overrun}, 1);
    done = 1'b0;
    @(negedge clk); done = 1'b1;
    repeat (10) @(negedge clk);
    check("pre_rst_col", {16'b0, m_col}, 2);
    check("pre_rst_row", {16'b0, m_row}, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, m_valid}, 0);
    check("mid_rst_data", {16'b0, m_data}, 0);
    check("mid_rst_rowcol", {m_row, m_col}, 0);
    check("mid_rst_flags", {28'b0, m_last, busy, frame_done, overrun}, 0);
    @(negedge clk); rst = 1'b0; done = 1'b0;
    @(negedge clk);
    check("rst_no_fd", {31'b0, frame_done}, 0);
    done = 1'b1;
    stream_frame(1'b0, -1, -1);
    result[3*16 +: 16] = 16'h8005;
    result[4*16 +: 16] = 16'h7FFF;
`ifdef CONV_STREAM_RELU_EN
    exp_w[3] = 16'h0000;
`else
    exp_w[3] = 16'h8005;
`endif
    exp_w[4] = 16'h7FFF;
    done = 1'b0;
    @(negedge clk); done = 1'b1;
    stream_frame(1'b0, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_result_streamer.md
# conv_result_streamer

Serializes the flat convolution result bus into a stream of 16-bit words with a valid/ready handshake. It sits downstream of the convolution top and is the reader of its `result`/`done` interface. On the rising edge of `done` it snapshots the full result vector, then emits it word by word in row-major order, tagging each word with row, column and last markers.

## Interface
- `OUT`, default 7: output map side length (IMAGE_HEIGHT − FILTER_SIZE + 1); the map has OUT×OUT words.
- `DATA_W`, default 16: result word width. Must match the 16-bit packing of the result bus.
- `IDX_W`, default 16: width of the row and column tags.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `result`, input, OUT*OUT*DATA_W: flat result map. Word k = row*OUT+col sits at bits [k*DATA_W +: DATA_W].
- `done`, input, 1: level-high completion flag from the convolution top. Only its rising edge is used.
- `m_data`, output, DATA_W: current stream word.
- `m_valid`, output, 1: `m_data` and the tags are valid.
- `m_ready`, input, 1: sink accepts the word.
- `m_row`, output, IDX_W: row index of the current word.
- `m_col`, output, IDX_W: column index of the current word.
- `m_last`, output, 1: the current word is index OUT*OUT−1.
- `busy`, output, 1: a frame is being streamed.
- `frame_done`, output, 1: one-cycle pulse after the last word is accepted.
- `overrun`, output, 1: sticky flag; a `done` rising edge arrived while busy.

## Operation
- Internal state:
  - `done_d` holds `done` delayed by one cycle.
  - `shadow` is an OUT*OUT*DATA_W snapshot register.
  - `row`/`col` are the word counters.
  - FSM states: IDLE and STREAM.
- A rising edge is defined as `done & ~done_d`.
- IDLE:
  - On a rising edge: `shadow` <= `result`; row = col = 0; `m_valid` <= 1; `busy` <= 1; go to STREAM.
  - `m_valid` is 0 in IDLE.
- STREAM:
  - `m_data` = `shadow` word at index row*OUT+col.
  - `m_row` = row, `m_col` = col, `m_last` = (row==OUT−1 && col==OUT−1).
- Transfer:
  - A transfer occurs on a cycle with `m_valid && m_ready`.
  - On transfer, col increments. At col==OUT−1, col wraps to 0 and row increments.
- Transfer with `m_last`:
  - `m_valid` <= 0, `busy` <= 0, `frame_done` <= 1 for one cycle, go to IDLE.
- Handshake rules:
  - While `m_valid`=1 and `m_ready`=0, the word, tags and `m_valid` hold stable.
  - `m_valid` never drops without a transfer.
- `shadow` is frozen during STREAM. Changes on `result` do not affect the frame in flight.
- Overrun: a rising edge in STREAM, including the cycle of the last transfer, sets `overrun`. That rising edge is otherwise ignored and starts no frame. `overrun` is cleared only by `rst`.
- `done` held high continuously produces exactly one frame.
- Data is passed through unchanged unless the ReLU option below is compiled in.

## Timing
- Reset values: `m_data`=0, `m_valid`=0, `m_row`=0, `m_col`=0, `m_last`=0, `busy`=0, `frame_done`=0, `overrun`=0, `done_d`=0, `shadow`=0, state IDLE.
- If `done` is high at reset release, the first edge after release counts as a rising edge and starts a frame.
- Latency: with `done` first sampled high at edge N, `m_valid` is high after edge N, so word 0 is presentable in cycle N+1.
- Throughput: one word per cycle with `m_ready` held high. A frame then takes OUT*OUT cycles.
- `frame_done` is high in the cycle after the last transfer edge.
- The earliest next frame starts on a rising edge sampled in IDLE, so at least one IDLE cycle separates frames.
- Reset asserted mid-frame: all state returns to reset values immediately; the partial frame is discarded and `frame_done` is not pulsed.

## Configuration
- `CONV_STREAM_RELU_EN` defined:
  - `m_data` = 0 when the selected shadow word has MSB 1 (negative in two's complement); otherwise the word.
  - `m_row`/`m_col`/`m_last` timing is unaffected.
- Undefined: `m_data` is the raw shadow word.

## Test plan
- Reset, then `result` word k = k+1 (OUT=7), `done` 0→1, `m_ready`=1:
  - 49 consecutive transfers with data 1..49 and (row,col) (0,0)..(6,6).
  - `m_last` only on word 49; `frame_done` pulses once; `busy` low after.
- Same frame with `m_ready` toggling 1,0,0,1,…:
  - Data and tags hold while `m_ready`=0.
  - No word is lost or duplicated; all 49 arrive in order.
- `result` changed to all 0xFFFF right after the `done` edge:
  - The stream still shows the snapshot values 1..49.
- `done` falls then rises again during word 20:
  - `overrun`=1 and stays 1.
  - The stream continues to word 49 and ends; no second frame starts.
- `rst` asserted at word 10:
  - Outputs return to reset values the same cycle.
  - After release with a fresh `done` edge, a full frame starts at (0,0).
- With `CONV_STREAM_RELU_EN`, word 3 = 16'h8005 and word 4 = 16'h7FFF:
  - Streamed as 16'h0000 and 16'h7FFF.
- Without `CONV_STREAM_RELU_EN`, the same words stream as 16'h8005 and 16'h7FFF.
